// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling ratio and
// the baud divisor helper that the TX and RX sides both use.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int OVERSAMPLE = 16;

    // System clocks per oversample tick, truncated toward zero.
    function automatic int baud_div(input int clock_freq, input int baud);
        return clock_freq / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with power-of-two depth. The occupancy counter has one extra
// bit so that full and empty are distinct. The read side is a show-ahead
// (combinational) head, forced to zero while the FIFO is empty.
module uart_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [AW-1:0]    PTR_ONE = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push that is paired with a pop.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array is written without reset; stale entries are never visible past the empty gate.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// 16x-oversampled UART receiver with 7/8/9 majority sampling, optional parity,
// framing/overrun reporting and a valid/ready output FIFO.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int DIV   = baud_div(CLOCK_FREQ, BAUD_RATE);
    localparam int DIV_W = $clog2(DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic             ODD      = (PARITY_ODD != 0);

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 prev_q, prev_d;
    rx_state_t            state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [3:0]           tick_idx_q, tick_idx_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 samp7_q, samp7_d;
    logic                 samp8_q, samp8_d;
    logic                 par_bad_q, par_bad_d;
    logic                 stop_ok_q, stop_ok_d;
    logic                 done_q, done_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;

    logic tick;
    logic majority;
    logic mid_tick;
    logic last_tick;
    logic good_byte;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_pop;
    logic fifo_push;

    assign tick      = (state_q != IDLE) && (div_q == DIV_LAST);
    assign mid_tick  = tick && (tick_idx_q == 4'd9);
    assign last_tick = tick && (tick_idx_q == 4'd15);
    assign majority  = (samp7_q & samp8_q) | (samp7_q & sync2_q) | (samp8_q & sync2_q);
    assign good_byte = done_q && stop_ok_q && !par_bad_q;
    assign fifo_pop  = !fifo_empty && rx_ready;
    assign fifo_push = good_byte && (!fifo_full || fifo_pop);

    assign rx_valid   = !fifo_empty;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (shift_q),
        .pop       (fifo_pop),
        .pop_data  (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (rx_count)
    );

    // Next-state logic: synchronizer, tick generator, frame FSM and the one-cycle disposition of a finished frame.
    always_comb begin
        sync1_d      = rx;
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        state_d      = state_q;
        div_d        = div_q;
        tick_idx_d   = tick_idx_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        samp7_d      = samp7_q;
        samp8_d      = samp8_q;
        par_bad_d    = par_bad_q;
        stop_ok_d    = stop_ok_q;
        done_d       = 1'b0;
        frame_err_d  = done_q && !stop_ok_q;
        parity_err_d = done_q && stop_ok_q && par_bad_q;
        overrun_d    = good_byte && fifo_full && !fifo_pop;

        if (state_q == IDLE) begin
            div_d      = '0;
            tick_idx_d = '0;
            if (prev_q && !sync2_q) begin
                state_d   = START;
                bit_idx_d = '0;
                par_bad_d = 1'b0;
            end
        end else begin
            div_d = tick ? '0 : (div_q + DIV_ONE);
            if (tick) begin
                tick_idx_d = tick_idx_q + 4'd1;
                if (tick_idx_q == 4'd7) begin
                    samp7_d = sync2_q;
                end
                if (tick_idx_q == 4'd8) begin
                    samp8_d = sync2_q;
                end
            end
            case (state_q)
                START: begin
                    if (mid_tick && majority) begin
                        state_d = IDLE;
                    end else if (last_tick) begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (mid_tick) begin
                        shift_d = {majority, shift_q[DATA_BITS-1:1]};
                    end
                    if (last_tick) begin
                        if (bit_idx_q == LAST_BIT) begin
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (mid_tick) begin
                        par_bad_d = ((^shift_q) ^ majority) != ODD;
                    end
                    if (last_tick) begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (mid_tick) begin
                        stop_ok_d = majority;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers; the synchronizer and edge detector reset to the idle-high line level.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            prev_q       <= 1'b1;
            state_q      <= IDLE;
            div_q        <= '0;
            tick_idx_q   <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            samp7_q      <= 1'b1;
            samp8_q      <= 1'b1;
            par_bad_q    <= 1'b0;
            stop_ok_q    <= 1'b0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            state_q      <= state_d;
            div_q        <= div_d;
            tick_idx_q   <= tick_idx_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            samp7_q      <= samp7_d;
            samp8_q      <= samp8_d;
            par_bad_q    <= par_bad_d;
            stop_ok_q    <= stop_ok_d;
            done_q       <= done_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered: a parity-free receiver and an even-parity
// receiver share clock and reset; the bench bit-bangs frames onto each line.
module tb_uart_rx_buffered;

    // 640 kHz / (10 kbaud * 16) gives 4 clocks per tick and 64 clocks per bit.
    localparam int CLK_F     = 640_000;
    localparam int BAUD      = 10_000;
    localparam int BIT_CLKS  = 64;
    localparam int IDLE_CLKS = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] rx_count;
    logic       frame_err, parity_err, overrun;

    logic       rx_p = 1'b1;
    logic       rx_ready_p = 1'b0;
    logic [7:0] rx_data_p;
    logic       rx_valid_p;
    logic [3:0] rx_count_p;
    logic       frame_err_p, parity_err_p, overrun_p;

    int n_compared = 0;
    int n_mismatched = 0;

    int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
    int fe_p_cnt = 0, pe_p_cnt = 0, ov_p_cnt = 0;
    logic [7:0] got_q[$];

    always #5 clock = ~clock;

    uart_rx_buffered #(
        .CLOCK_FREQ (CLK_F), .BAUD_RATE (BAUD), .DATA_BITS (8),
        .PARITY_EN (0), .PARITY_ODD (0), .FIFO_DEPTH (8)
    ) dut (
        .clock (clock), .reset (reset), .rx (rx),
        .rx_data (rx_data), .rx_valid (rx_valid), .rx_ready (rx_ready),
        .rx_count (rx_count), .frame_err (frame_err),
        .parity_err (parity_err), .overrun (overrun)
    );

    uart_rx_buffered #(
        .CLOCK_FREQ (CLK_F), .BAUD_RATE (BAUD), .DATA_BITS (8),
        .PARITY_EN (1), .PARITY_ODD (0), .FIFO_DEPTH (8)
    ) dut_p (
        .clock (clock), .reset (reset), .rx (rx_p),
        .rx_data (rx_data_p), .rx_valid (rx_valid_p), .rx_ready (rx_ready_p),
        .rx_count (rx_count_p), .frame_err (frame_err_p),
        .parity_err (parity_err_p), .overrun (overrun_p)
    );

    // Record every handshake and error pulse, sampled on the falling edge between active edges.
    always @(negedge clock) begin
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (frame_err) fe_cnt++;
        if (parity_err) pe_cnt++;
        if (overrun) ov_cnt++;
        if (frame_err_p) fe_p_cnt++;
        if (parity_err_p) pe_p_cnt++;
        if (overrun_p) ov_p_cnt++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] data, input logic stop_bit);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_clks(BIT_CLKS);
        end
        rx = stop_bit;
        wait_clks(BIT_CLKS);
        rx = 1'b1;
        wait_clks(IDLE_CLKS);
    endtask

    task automatic send_byte_p(input logic [7:0] data, input logic par_bit);
        rx_p = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_p = data[i];
            wait_clks(BIT_CLKS);
        end
        rx_p = par_bit;
        wait_clks(BIT_CLKS);
        rx_p = 1'b1;
        wait_clks(BIT_CLKS + IDLE_CLKS);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx = 1'b1;
        rx_p = 1'b1;
        wait_clks(5);
        reset = 1'b0;
        wait_clks(3);
        n_compared++; if (rx_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", rx_valid); end
        n_compared++; if (rx_count !== 4'd0) begin n_mismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", rx_count); end
        n_compared++; if (rx_data !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_data: got %h expected 00", rx_data); end
        n_compared++; if ((fe_cnt + pe_cnt + ov_cnt) !== 0) begin n_mismatched++; $display("[TB] FAIL reset_pulses: got %0d expected 0", fe_cnt + pe_cnt + ov_cnt); end
        n_compared++; if (rx_count_p !== 4'd0) begin n_mismatched++; $display("[TB] FAIL reset_count_p: got %0d expected 0", rx_count_p); end
    endtask

    task automatic test_loopback();
        logic [7:0] exp_bytes [5] = '{8'h55, 8'hA5, 8'h00, 8'hFF, 8'h3C};
        int base = got_q.size();
        int fe0 = fe_cnt, pe0 = pe_cnt, ov0 = ov_cnt;
        logic [7:0] obs;
        rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_byte(exp_bytes[i], 1'b1);
        n_compared++; if (got_q.size() - base !== 5) begin n_mismatched++; $display("[TB] FAIL loop_pops: got %0d expected 5", got_q.size() - base); end
        for (int i = 0; i < 5; i++) begin
            obs = (base + i < got_q.size()) ? got_q[base + i] : 8'hxx;
            n_compared++; if (obs !== exp_bytes[i]) begin n_mismatched++; $display("[TB] FAIL loop_data[%0d]: got %h expected %h", i, obs, exp_bytes[i]); end
        end
        n_compared++; if ((fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0) !== 0) begin n_mismatched++; $display("[TB] FAIL loop_errs: got %0d expected 0", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0)); end
    endtask

    task automatic test_overrun();
        int base;
        int ov0 = ov_cnt, fe0 = fe_cnt;
        logic [7:0] obs;
        rx_ready = 1'b0;
        wait_clks(2);
        base = got_q.size();
        for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1);
        n_compared++; if (rx_count !== 4'd8) begin n_mismatched++; $display("[TB] FAIL ovr_count: got %0d expected 8", rx_count); end
        n_compared++; if (ov_cnt - ov0 !== 1) begin n_mismatched++; $display("[TB] FAIL ovr_pulses: got %0d expected 1", ov_cnt - ov0); end
        n_compared++; if (fe_cnt - fe0 !== 0) begin n_mismatched++; $display("[TB] FAIL ovr_frame: got %0d expected 0", fe_cnt - fe0); end
        n_compared++; if (rx_data !== 8'h01) begin n_mismatched++; $display("[TB] FAIL ovr_head: got %h expected 01", rx_data); end
        rx_ready = 1'b1;
        wait_clks(20);
        n_compared++; if (got_q.size() - base !== 8) begin n_mismatched++; $display("[TB] FAIL ovr_drain_n: got %0d expected 8", got_q.size() - base); end
        for (int i = 0; i < 8; i++) begin
            obs = (base + i < got_q.size()) ? got_q[base + i] : 8'hxx;
            n_compared++; if (obs !== 8'(i + 1)) begin n_mismatched++; $display("[TB] FAIL ovr_drain[%0d]: got %h expected %h", i, obs, 8'(i + 1)); end
        end
        n_compared++; if (rx_count !== 4'd0) begin n_mismatched++; $display("[TB] FAIL ovr_empty: got %0d expected 0", rx_count); end
    endtask

    task automatic test_frame_error();
        int base = got_q.size();
        int fe0 = fe_cnt, pe0 = pe_cnt;
        logic [7:0] obs;
        rx_ready = 1'b1;
        send_byte(8'hA5, 1'b0);
        n_compared++; if (fe_cnt - fe0 !== 1) begin n_mismatched++; $display("[TB] FAIL ferr_pulses: got %0d expected 1", fe_cnt - fe0); end
        n_compared++; if (got_q.size() - base !== 0) begin n_mismatched++; $display("[TB] FAIL ferr_pops: got %0d expected 0", got_q.size() - base); end
        n_compared++; if (rx_count !== 4'd0) begin n_mismatched++; $display("[TB] FAIL ferr_count: got %0d expected 0", rx_count); end
        send_byte(8'h3C, 1'b1);
        obs = (base < got_q.size()) ? got_q[base] : 8'hxx;
        n_compared++; if (obs !== 8'h3C) begin n_mismatched++; $display("[TB] FAIL ferr_next: got %h expected 3C", obs); end
        n_compared++; if ((fe_cnt - fe0) + (pe_cnt - pe0) !== 1) begin n_mismatched++; $display("[TB] FAIL ferr_total: got %0d expected 1", (fe_cnt - fe0) + (pe_cnt - pe0)); end
    endtask

    task automatic test_glitch();
        int base = got_q.size();
        int e0 = fe_cnt + pe_cnt + ov_cnt;
        logic [7:0] obs;
        rx_ready = 1'b1;
        rx = 1'b0;
        wait_clks(16);
        rx = 1'b1;
        wait_clks(200);
        n_compared++; if (got_q.size() - base !== 0) begin n_mismatched++; $display("[TB] FAIL glitch_pops: got %0d expected 0", got_q.size() - base); end
        n_compared++; if (fe_cnt + pe_cnt + ov_cnt - e0 !== 0) begin n_mismatched++; $display("[TB] FAIL glitch_errs: got %0d expected 0", fe_cnt + pe_cnt + ov_cnt - e0); end
        send_byte(8'h55, 1'b1);
        obs = (base < got_q.size()) ? got_q[base] : 8'hxx;
        n_compared++; if (obs !== 8'h55) begin n_mismatched++; $display("[TB] FAIL glitch_next: got %h expected 55", obs); end
    endtask

    task automatic test_parity();
        int pe0 = pe_p_cnt, fe0 = fe_p_cnt, ov0 = ov_p_cnt;
        rx_ready_p = 1'b0;
        send_byte_p(8'h01, 1'b0);
        n_compared++; if (pe_p_cnt - pe0 !== 1) begin n_mismatched++; $display("[TB] FAIL par_bad_pulse: got %0d expected 1", pe_p_cnt - pe0); end
        n_compared++; if (rx_count_p !== 4'd0) begin n_mismatched++; $display("[TB] FAIL par_bad_count: got %0d expected 0", rx_count_p); end
        send_byte_p(8'h01, 1'b1);
        n_compared++; if (rx_count_p !== 4'd1) begin n_mismatched++; $display("[TB] FAIL par_ok_count: got %0d expected 1", rx_count_p); end
        n_compared++; if (rx_data_p !== 8'h01) begin n_mismatched++; $display("[TB] FAIL par_ok_data: got %h expected 01", rx_data_p); end
        n_compared++; if (pe_p_cnt - pe0 !== 1) begin n_mismatched++; $display("[TB] FAIL par_ok_pulse: got %0d expected 1", pe_p_cnt - pe0); end
        n_compared++; if ((fe_p_cnt - fe0) + (ov_p_cnt - ov0) !== 0) begin n_mismatched++; $display("[TB] FAIL par_other: got %0d expected 0", (fe_p_cnt - fe0) + (ov_p_cnt - ov0)); end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        int e0 = fe_cnt + pe_cnt + ov_cnt;
        logic [7:0] obs;
        rx_ready = 1'b0;
        send_byte(8'h5A, 1'b1);
        n_compared++; if (rx_count !== 4'd1) begin n_mismatched++; $display("[TB] FAIL rmid_pre_count: got %0d expected 1", rx_count); end
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        rx = 1'b1;
        wait_clks(100);
        reset = 1'b1;
        wait_clks(1);
        reset = 1'b0;
        wait_clks(10 * BIT_CLKS - BIT_CLKS - 101 + IDLE_CLKS);
        n_compared++; if (rx_count !== 4'd0) begin n_mismatched++; $display("[TB] FAIL rmid_count: got %0d expected 0", rx_count); end
        n_compared++; if (rx_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rmid_valid: got %b expected 0", rx_valid); end
        n_compared++; if (fe_cnt + pe_cnt + ov_cnt - e0 !== 0) begin n_mismatched++; $display("[TB] FAIL rmid_pulses: got %0d expected 0", fe_cnt + pe_cnt + ov_cnt - e0); end
        rx_ready = 1'b1;
        base = got_q.size();
        send_byte(8'h3C, 1'b1);
        n_compared++; if (got_q.size() - base !== 1) begin n_mismatched++; $display("[TB] FAIL rmid_pops: got %0d expected 1", got_q.size() - base); end
        obs = (base < got_q.size()) ? got_q[base] : 8'hxx;
        n_compared++; if (obs !== 8'h3C) begin n_mismatched++; $display("[TB] FAIL rmid_next: got %h expected 3C", obs); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_overrun();
        test_frame_error();
        test_glitch();
        test_parity();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
